// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with HI/LO registers and fixed 5/10-cycle busy windows.
// Optional Abort input is compiled in when MDU_ABORT_EN is defined.
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
`ifdef MDU_ABORT_EN
    input  logic        Abort,
`endif
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_pend_q, hi_pend_d;
    logic [31:0] lo_pend_q, lo_pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        abort_req;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

`ifdef MDU_ABORT_EN
    assign abort_req = Abort;
`else
    assign abort_req = 1'b0;
`endif

    // Signed product taken as the low 64 bits of a sign-extended multiply.
    always_comb begin
        if (MDUOp == OP_MULT) begin
            prod = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
        end else begin
            prod = {32'b0, SrcA} * {32'b0, SrcB};
        end
    end

    // Divide by zero reuses the current HI/LO so completion leaves them unchanged.
    always_comb begin
        quot = lo_q;
        rem  = hi_q;
        if (SrcB != 32'b0) begin
            if (MDUOp == OP_DIV) begin
                if (SrcA == 32'h8000_0000 && SrcB == 32'hFFFF_FFFF) begin
                    quot = 32'h8000_0000;
                    rem  = 32'b0;
                end else begin
                    quot = $signed(SrcA) / $signed(SrcB);
                    rem  = $signed(SrcA) % $signed(SrcB);
                end
            end else begin
                quot = SrcA / SrcB;
                rem  = SrcA % SrcB;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            hi_pend_d = prod[63:32];
                            lo_pend_d = prod[31:0];
                            cnt_d     = 4'd5;
                            state_d   = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            hi_pend_d = rem;
                            lo_pend_d = quot;
                            cnt_d     = 4'd10;
                            state_d   = ST_DIV;
                        end
                        OP_MTHI: hi_d = SrcA;
                        OP_MTLO: lo_d = SrcA;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (abort_req) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    hi_d    = hi_pend_q;
                    lo_d    = lo_pend_q;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            hi_pend_q <= 32'b0;
            lo_pend_q <= 32'b0;
            hi_q      <= 32'b0;
            lo_q      <= 32'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
